// File: rtl/ysyx_23060203_pkg.sv
// ysyx_23060203_pkg
//   Shared definitions for the memory read arbiter.
//   - ST_* : arbiter state encodings (legacy-compatible constants)
//   - arb_state_t : arbiter FSM state type built on those encodings
//   - MST_IFU / MST_LSU : master-select encoding used for last_grant
package ysyx_23060203_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_AR_IFU = 3'd1;
    localparam logic [2:0] ST_R_IFU  = 3'd2;
    localparam logic [2:0] ST_AR_LSU = 3'd3;
    localparam logic [2:0] ST_R_LSU  = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        AR_IFU = ST_AR_IFU,
        R_IFU  = ST_R_IFU,
        AR_LSU = ST_AR_LSU,
        R_LSU  = ST_R_LSU
    } arb_state_t;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060203_mem_arbiter.sv
// ysyx_23060203_mem_arbiter
//   Shares the single memory read port between the IFU and the LSU, one
//   outstanding read at a time. Grant is registered in IDLE and held until
//   the rlast beat of the granted read. The LSU write channel is a pure
//   combinational pass-through.
//   Parameter LSU_PRIO: 1 = LSU wins ties, 0 = round-robin on ties.
//   Ports:
//     clock, reset          : core clock, synchronous active-high reset
//     ifu_* / lsu_* (AR, R) : read channels from the two masters
//     lsu_* (AW, W, B)      : LSU write channel
//     mem_* (AR, R)         : shared read master towards memory
//     mem_* (AW, W, B)      : write master towards memory
module ysyx_23060203_mem_arbiter
    import ysyx_23060203_pkg::*;
#(
    parameter int unsigned LSU_PRIO = 1
) (
    input  logic        clock,
    input  logic        reset,
    // IFU read channel
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic        ifu_rlast,
    // LSU read channel
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic        lsu_rlast,
    // LSU write channel
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    input  logic        lsu_wlast,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    // memory read master
    output logic [31:0] mem_araddr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic        mem_rlast,
    // memory write master
    output logic [31:0] mem_awaddr,
    output logic        mem_awvalid,
    input  logic        mem_awready,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_wvalid,
    output logic        mem_wlast,
    input  logic        mem_wready,
    input  logic [1:0]  mem_bresp,
    input  logic        mem_bvalid,
    output logic        mem_bready
);

    localparam logic PRIO_LSU = (LSU_PRIO != 0);

    arb_state_t state;
    logic       last_grant;
    logic       pick_lsu;

    // Tie: fixed LSU priority, or the master that did not win last time.
    always_comb begin
        pick_lsu = lsu_arvalid;
        if (lsu_arvalid && ifu_arvalid) begin
            pick_lsu = PRIO_LSU || (last_grant == MST_IFU);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= MST_IFU;
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_arvalid || lsu_arvalid) begin
                        state      <= pick_lsu ? AR_LSU : AR_IFU;
                        last_grant <= pick_lsu ? MST_LSU : MST_IFU;
                    end
                end
                AR_IFU: if (ifu_arvalid && mem_arready) state <= R_IFU;
                AR_LSU: if (lsu_arvalid && mem_arready) state <= R_LSU;
                R_IFU:  if (mem_rvalid && ifu_rready && mem_rlast) state <= IDLE;
                R_LSU:  if (mem_rvalid && lsu_rready && mem_rlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read routing is purely a function of the registered state, so a new
    // request in IDLE can never reach mem_arvalid in the same cycle.
    always_comb begin
        mem_araddr  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rlast   = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rlast   = 1'b0;
        case (state)
            AR_IFU: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid;
                ifu_arready = mem_arready;
            end
            AR_LSU: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid;
                lsu_arready = mem_arready;
            end
            R_IFU: begin
                ifu_rvalid = mem_rvalid;
                ifu_rlast  = mem_rlast;
                mem_rready = ifu_rready;
            end
            R_LSU: begin
                lsu_rvalid = mem_rvalid;
                lsu_rlast  = mem_rlast;
                mem_rready = lsu_rready;
            end
            default: ;
        endcase
    end

    // Data and response are qualified by rvalid, so they fan out unmuxed.
    assign ifu_rdata = mem_rdata;
    assign ifu_rresp = mem_rresp;
    assign lsu_rdata = mem_rdata;
    assign lsu_rresp = mem_rresp;

    assign mem_awaddr  = lsu_awaddr;
    assign mem_awvalid = lsu_awvalid;
    assign lsu_awready = mem_awready;
    assign mem_wdata   = lsu_wdata;
    assign mem_wstrb   = lsu_wstrb;
    assign mem_wvalid  = lsu_wvalid;
    assign mem_wlast   = lsu_wlast;
    assign lsu_wready  = mem_wready;
    assign lsu_bresp   = mem_bresp;
    assign lsu_bvalid  = mem_bvalid;
    assign mem_bready  = lsu_bready;

endmodule

// File: tb/tb_ysyx_23060203_mem_arbiter.sv
// Bench for ysyx_23060203_mem_arbiter: dut0 uses round-robin ties,
// dut1 uses fixed LSU priority; both share stimulus and the memory model.
module tb_ysyx_23060203_mem_arbiter;
    import ysyx_23060203_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // master-side inputs
    logic [31:0] ifu_araddr = '0, lsu_araddr = '0;
    logic        ifu_arvalid = 1'b0, lsu_arvalid = 1'b0;
    logic        ifu_rready = 1'b1, lsu_rready = 1'b1;
    logic [31:0] lsu_awaddr = '0, lsu_wdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic        lsu_awvalid = 1'b0, lsu_wvalid = 1'b0, lsu_wlast = 1'b0, lsu_bready = 1'b0;
    // memory-side inputs
    logic        mem_arready = 1'b1;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  mem_rresp = '0;
    logic        mem_rvalid = 1'b0, mem_rlast = 1'b0;
    logic        mem_awready = 1'b1, mem_wready = 1'b1;
    logic [1:0]  mem_bresp = '0;
    logic        mem_bvalid = 1'b0;

    // dut outputs
    logic        d0_ifu_arready, d0_ifu_rvalid, d0_ifu_rlast, d0_lsu_arready, d0_lsu_rvalid, d0_lsu_rlast;
    logic [31:0] d0_ifu_rdata, d0_lsu_rdata, d0_mem_araddr, d0_mem_awaddr, d0_mem_wdata;
    logic [1:0]  d0_ifu_rresp, d0_lsu_rresp, d0_lsu_bresp;
    logic        d0_lsu_awready, d0_lsu_wready, d0_lsu_bvalid, d0_mem_arvalid, d0_mem_rready;
    logic        d0_mem_awvalid, d0_mem_wvalid, d0_mem_wlast, d0_mem_bready;
    logic [3:0]  d0_mem_wstrb;
    logic        d1_ifu_arready, d1_ifu_rvalid, d1_ifu_rlast, d1_lsu_arready, d1_lsu_rvalid, d1_lsu_rlast;
    logic [31:0] d1_ifu_rdata, d1_lsu_rdata, d1_mem_araddr, d1_mem_awaddr, d1_mem_wdata;
    logic [1:0]  d1_ifu_rresp, d1_lsu_rresp, d1_lsu_bresp;
    logic        d1_lsu_awready, d1_lsu_wready, d1_lsu_bvalid, d1_mem_arvalid, d1_mem_rready;
    logic        d1_mem_awvalid, d1_mem_wvalid, d1_mem_wlast, d1_mem_bready;
    logic [3:0]  d1_mem_wstrb;

    ysyx_23060203_mem_arbiter #(.LSU_PRIO(0)) dut0 (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(d0_ifu_arready),
        .ifu_rdata(d0_ifu_rdata), .ifu_rresp(d0_ifu_rresp), .ifu_rvalid(d0_ifu_rvalid),
        .ifu_rready(ifu_rready), .ifu_rlast(d0_ifu_rlast),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(d0_lsu_arready),
        .lsu_rdata(d0_lsu_rdata), .lsu_rresp(d0_lsu_rresp), .lsu_rvalid(d0_lsu_rvalid),
        .lsu_rready(lsu_rready), .lsu_rlast(d0_lsu_rlast),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(d0_lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wlast(lsu_wlast),
        .lsu_wready(d0_lsu_wready), .lsu_bresp(d0_lsu_bresp), .lsu_bvalid(d0_lsu_bvalid),
        .lsu_bready(lsu_bready),
        .mem_araddr(d0_mem_araddr), .mem_arvalid(d0_mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
        .mem_rready(d0_mem_rready), .mem_rlast(mem_rlast),
        .mem_awaddr(d0_mem_awaddr), .mem_awvalid(d0_mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(d0_mem_wdata), .mem_wstrb(d0_mem_wstrb), .mem_wvalid(d0_mem_wvalid),
        .mem_wlast(d0_mem_wlast), .mem_wready(mem_wready), .mem_bresp(mem_bresp),
        .mem_bvalid(mem_bvalid), .mem_bready(d0_mem_bready)
    );

    ysyx_23060203_mem_arbiter #(.LSU_PRIO(1)) dut1 (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(d1_ifu_arready),
        .ifu_rdata(d1_ifu_rdata), .ifu_rresp(d1_ifu_rresp), .ifu_rvalid(d1_ifu_rvalid),
        .ifu_rready(ifu_rready), .ifu_rlast(d1_ifu_rlast),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(d1_lsu_arready),
        .lsu_rdata(d1_lsu_rdata), .lsu_rresp(d1_lsu_rresp), .lsu_rvalid(d1_lsu_rvalid),
        .lsu_rready(lsu_rready), .lsu_rlast(d1_lsu_rlast),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(d1_lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wlast(lsu_wlast),
        .lsu_wready(d1_lsu_wready), .lsu_bresp(d1_lsu_bresp), .lsu_bvalid(d1_lsu_bvalid),
        .lsu_bready(lsu_bready),
        .mem_araddr(d1_mem_araddr), .mem_arvalid(d1_mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
        .mem_rready(d1_mem_rready), .mem_rlast(mem_rlast),
        .mem_awaddr(d1_mem_awaddr), .mem_awvalid(d1_mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(d1_mem_wdata), .mem_wstrb(d1_mem_wstrb), .mem_wvalid(d1_mem_wvalid),
        .mem_wlast(d1_mem_wlast), .mem_wready(mem_wready), .mem_bresp(mem_bresp),
        .mem_bvalid(mem_bvalid), .mem_bready(d1_mem_bready)
    );

    // memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a, input int unsigned b);
        if (a == 32'h8000_0000 && b == 0) return 32'h0000_0413;
        return (a ^ 32'hA5A5_0000) + b * 32'h0101_0101;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        return (a == 32'h8000_2000) ? 2'b10 : 2'b00;
    endfunction

    // memory model: follows dut0's read port; burst length and stall are
    // taken from the cfg values at the AR handshake
    int unsigned mem_len_cfg = 1, mem_stall_cfg = 0;
    logic        mm_rst, mm_ar, mm_r, mm_active = 1'b0;
    logic [31:0] mm_saddr, mm_addr;
    int unsigned mm_slen, mm_sstall, mm_len, mm_stall_len, mm_stall, mm_beat;

    always begin
        @(negedge clock);
        mm_rst    = reset;
        mm_ar     = d0_mem_arvalid && mem_arready;
        mm_saddr  = d0_mem_araddr;
        mm_r      = mem_rvalid && d0_mem_rready;
        mm_slen   = mem_len_cfg;
        mm_sstall = mem_stall_cfg;
        @(posedge clock);
        #1;
        if (mm_rst) begin
            mm_active = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
        end else if (mm_ar) begin
            mm_active = 1'b1; mm_addr = mm_saddr; mm_len = mm_slen;
            mm_stall_len = mm_sstall; mm_stall = 0; mm_beat = 0;
            mem_rvalid = 1'b1; mem_rdata = mem_word(mm_addr, mm_beat);
            mem_rresp = mem_resp(mm_addr); mem_rlast = (mm_beat == mm_len - 1);
        end else if (mm_active) begin
            if (mm_r) begin
                if (mem_rlast) begin
                    mm_active = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
                end else begin
                    mm_beat++;
                    if (mm_beat == 2 && mm_stall_len > 0) begin
                        mm_stall = mm_stall_len; mem_rvalid = 1'b0;
                    end else begin
                        mem_rvalid = 1'b1; mem_rdata = mem_word(mm_addr, mm_beat);
                        mem_rlast = (mm_beat == mm_len - 1);
                    end
                end
            end else if (mm_stall > 0) begin
                mm_stall--;
                if (mm_stall == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = mem_word(mm_addr, mm_beat);
                    mem_rlast = (mm_beat == mm_len - 1);
                end
            end
        end
    end

    // scoreboard and bookkeeping
    int    total = 0, bad = 0, cyc = 0;
    beat_t ifu_q[$], lsu_q[$];
    logic  g0[$], g1[$];
    int    rlast_cycs[$], ar_rises[$];
    int    ifu_rlast_cyc, lsu_ar_cyc, beats_ifu = 0, beats_lsu = 0;
    logic  hold = 1'b0, prev_ar0 = 1'b0, snap_ar0;
    logic [5:0]  snap_outs0, snap_outs1;
    logic [71:0] snap_w;
    logic [4:0]  snap_wb;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag, input logic [95:0] obs);
        total++;
        bad++;
        $error("FAIL %s observed=%0h expected=none", tag, obs);
    endtask

    task automatic check_beat(input logic m, input beat_t obs);
        beat_t e;
        if (m == MST_IFU) begin
            if (ifu_q.size() == 0) begin fail_now("ifu_beat_unexpected", obs); return; end
            e = ifu_q.pop_front();
            chk("ifu_beat", obs, e);
        end else begin
            if (lsu_q.size() == 0) begin fail_now("lsu_beat_unexpected", obs); return; end
            e = lsu_q.pop_front();
            chk("lsu_beat", obs, e);
        end
    endtask

    // one cycle: sample at negedge, then return just after the next posedge
    task automatic step();
        logic ih, lh;
        @(negedge clock);
        cyc++;
        snap_ar0   = d0_mem_arvalid;
        snap_outs0 = {d0_mem_arvalid, d0_mem_rready, d0_ifu_arready, d0_lsu_arready, d0_ifu_rvalid, d0_lsu_rvalid};
        snap_outs1 = {d1_mem_arvalid, d1_mem_rready, d1_ifu_arready, d1_lsu_arready, d1_ifu_rvalid, d1_lsu_rvalid};
        snap_w     = {d0_mem_awaddr, d0_mem_awvalid, d0_mem_wdata, d0_mem_wstrb, d0_mem_wvalid, d0_mem_wlast, d0_mem_bready};
        snap_wb    = {d0_lsu_awready, d0_lsu_wready, d0_lsu_bvalid, d0_lsu_bresp};
        if (d0_ifu_rvalid && ifu_rready) begin
            check_beat(MST_IFU, {d0_ifu_rdata, d0_ifu_rresp, d0_ifu_rlast});
            beats_ifu++;
            if (d0_ifu_rlast) ifu_rlast_cyc = cyc;
        end
        if (d0_lsu_rvalid && lsu_rready) begin
            check_beat(MST_LSU, {d0_lsu_rdata, d0_lsu_rresp, d0_lsu_rlast});
            beats_lsu++;
        end
        if (mem_rvalid && d0_mem_rready && mem_rlast) rlast_cycs.push_back(cyc);
        if (d0_mem_arvalid && !prev_ar0) ar_rises.push_back(cyc);
        prev_ar0 = d0_mem_arvalid;
        ih = ifu_arvalid && d0_ifu_arready;
        lh = lsu_arvalid && d0_lsu_arready;
        if (ih) g0.push_back(MST_IFU);
        if (lh) begin g0.push_back(MST_LSU); lsu_ar_cyc = cyc; end
        if (ifu_arvalid && d1_ifu_arready) g1.push_back(MST_IFU);
        if (lsu_arvalid && d1_lsu_arready) g1.push_back(MST_LSU);
        @(posedge clock);
        #1;
        if (ih && !hold) ifu_arvalid = 1'b0;
        if (lh && !hold) lsu_arvalid = 1'b0;
    endtask

    task automatic push_exp(input logic m, input logic [31:0] a, input int unsigned len);
        for (int unsigned i = 0; i < len; i++) begin
            beat_t e;
            e.data = mem_word(a, i);
            e.resp = mem_resp(a);
            e.last = (i == len - 1);
            if (m == MST_LSU) lsu_q.push_back(e); else ifu_q.push_back(e);
        end
    endtask

    task automatic issue(input logic m, input logic [31:0] a, input int unsigned len, input int unsigned stall);
        mem_len_cfg   = len;
        mem_stall_cfg = stall;
        push_exp(m, a, len);
        if (m == MST_LSU) begin lsu_araddr = a; lsu_arvalid = 1'b1; end
        else begin ifu_araddr = a; ifu_arvalid = 1'b1; end
    endtask

    task automatic run_until_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (ifu_q.size() == 0 && lsu_q.size() == 0 && !ifu_arvalid && !lsu_arvalid) return;
            step();
        end
        fail_now({tag, "_timeout"}, {ifu_q.size(), lsu_q.size()});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic chk_grant(input string tag, input logic q_is_d1, input logic exp);
        logic g;
        if (q_is_d1) begin
            if (g1.size() == 0) begin fail_now({tag, "_missing"}, 0); return; end
            g = g1.pop_front();
        end else begin
            if (g0.size() == 0) begin fail_now({tag, "_missing"}, 0); return; end
            g = g0.pop_front();
        end
        chk(tag, g, exp);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        step();
        step();
        chk("reset_outs_d0", snap_outs0, 6'b0);
        chk("reset_outs_d1", snap_outs1, 6'b0);
        reset = 1'b0;
        step();

        // single IFU read
        g0.delete(); g1.delete(); beats_lsu = 0;
        issue(MST_IFU, 32'h8000_0000, 1, 0);
        step();
        chk("t1_arvalid_same_cycle", snap_ar0, 1'b0);
        step();
        chk("t1_arvalid_next_cycle", snap_ar0, 1'b1);
        run_until_idle("t1");
        chk("t1_lsu_rvalid_beats", beats_lsu, 0);
        chk_grant("t1_grant", 1'b0, MST_IFU);

        // simultaneous requests after reset, round-robin
        do_reset();
        g0.delete(); g1.delete(); rlast_cycs.delete(); ar_rises.delete();
        issue(MST_LSU, 32'h8000_0100, 1, 0);
        issue(MST_IFU, 32'h8000_0200, 1, 0);
        run_until_idle("t2");
        chk_grant("t2_first_d0", 1'b0, MST_LSU);
        chk_grant("t2_second_d0", 1'b0, MST_IFU);
        chk_grant("t2_first_d1", 1'b1, MST_LSU);
        chk_grant("t2_second_d1", 1'b1, MST_IFU);
        if (ar_rises.size() >= 2 && rlast_cycs.size() >= 1)
            chk("t2_ar_gap", ar_rises[1] - rlast_cycs[0], 2);
        else
            fail_now("t2_ar_gap_missing", {ar_rises.size(), rlast_cycs.size()});

        // continuous requests from both masters, 4 grants
        do_reset();
        g0.delete(); g1.delete();
        hold = 1'b1;
        issue(MST_LSU, 32'h8000_0300, 1, 0);
        issue(MST_IFU, 32'h8000_0400, 1, 0);
        push_exp(MST_LSU, 32'h8000_0300, 1);
        push_exp(MST_IFU, 32'h8000_0400, 1);
        for (int i = 0; i < 60 && g0.size() < 4; i++) step();
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        hold = 1'b0;
        run_until_idle("t3");
        chk_grant("t3_rr_0", 1'b0, MST_LSU);
        chk_grant("t3_rr_1", 1'b0, MST_IFU);
        chk_grant("t3_rr_2", 1'b0, MST_LSU);
        chk_grant("t3_rr_3", 1'b0, MST_IFU);
        for (int i = 0; i < 4; i++) chk_grant("t3_prio", 1'b1, MST_LSU);

        // 4-beat IFU burst with a 3-cycle stall, LSU pending
        g0.delete(); g1.delete(); beats_ifu = 0;
        issue(MST_IFU, 32'h8000_3000, 4, 3);
        for (int i = 0; i < 20 && g0.size() == 0; i++) step();
        issue(MST_LSU, 32'h8000_3100, 1, 0);
        run_until_idle("t4");
        chk("t4_ifu_beats", beats_ifu, 4);
        chk("t4_lsu_after_rlast", lsu_ar_cyc - ifu_rlast_cyc, 2);
        chk_grant("t4_grant0", 1'b0, MST_IFU);
        chk_grant("t4_grant1", 1'b0, MST_LSU);

        // LSU write concurrent with an IFU read (error response passes through)
        g0.delete(); g1.delete();
        issue(MST_IFU, 32'h8000_2000, 2, 0);
        lsu_awaddr = 32'h8000_1000; lsu_awvalid = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_wvalid = 1'b1; lsu_wlast = 1'b1;
        lsu_bready = 1'b1;
        step();
        chk("t5_mem_w", snap_w, {32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b1});
        chk("t5_lsu_w_ready", snap_wb, {1'b1, 1'b1, 1'b0, 2'b00});
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; lsu_wlast = 1'b0;
        mem_bvalid = 1'b1; mem_bresp = 2'b01; mem_awready = 1'b0;
        step();
        chk("t5_lsu_b", snap_wb, {1'b0, 1'b1, 1'b1, 2'b01});
        mem_bvalid = 1'b0; mem_bresp = 2'b00; mem_awready = 1'b1; lsu_bready = 1'b0;
        run_until_idle("t5");
        chk_grant("t5_grant", 1'b0, MST_IFU);

        // reset while in R_LSU
        beats_lsu = 0;
        issue(MST_LSU, 32'h8000_4000, 4, 0);
        for (int i = 0; i < 20 && beats_lsu == 0; i++) step();
        if (beats_lsu == 0) fail_now("t6_no_lsu_beat", 0);
        reset = 1'b1;
        step();
        step();
        chk("t6_reset_outs_d0", snap_outs0, 6'b0);
        chk("t6_reset_outs_d1", snap_outs1, 6'b0);
        lsu_q.delete();
        reset = 1'b0;
        step();
        beats_ifu = 0;
        issue(MST_IFU, 32'h8000_5000, 1, 0);
        run_until_idle("t6");
        chk("t6_ifu_beats", beats_ifu, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
